// File: rtl/stream_mux_arb.sv
// Registered N-channel stream mux with fixed, priority and round-robin select; 1-cycle latency.
// Backpressure: inputs are accepted only while the output register is empty or being drained.
module stream_mux_arb #(
    parameter int NCH      = 3,
    parameter int WIDTH    = 8,
    parameter int NARROW_W = 3,
    parameter int PAD_ONES = 1,
    parameter int SELW     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch,
    output logic                 err_sel
);

    localparam logic [1:0]    MODE_PRIO = 2'b01;
    localparam logic [1:0]    MODE_RR   = 2'b10;
    localparam logic [SELW:0] NCH_W     = (SELW+1)'(NCH);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;
    logic             err_sel_q, err_sel_d;

    logic [WIDTH-1:0] ch_word [NCH];
    logic [NCH-1:0]   grant;
    logic [SELW:0]    idx;
    logic [SELW-1:0]  win_idx;
    logic [WIDTH-1:0] win_word;
    logic             fixed_mode, sel_bad, space, xfer;

    // The last channel only drives NARROW_W bits; the rest is a constant pad.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_word[i] = in_data[i*WIDTH +: WIDTH];
        end
        for (int b = NARROW_W; b < WIDTH; b++) begin
            ch_word[NCH-1][b] = (PAD_ONES != 0);
        end
    end

    assign fixed_mode = (mode == 2'b00) || (mode == 2'b11);
    assign sel_bad    = ({1'b0, sel} >= NCH_W);

    // Loops run from the least preferred candidate upward so the preferred one is written last.
    always_comb begin
        grant = '0;
        idx   = '0;
        case (mode)
            MODE_PRIO: begin
                for (int i = NCH-1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        grant    = '0;
                        grant[i] = 1'b1;
                    end
                end
            end
            MODE_RR: begin
                for (int off = NCH-1; off >= 0; off--) begin
                    idx = {1'b0, rr_ptr_q} + (SELW+1)'(off);
                    if (idx >= NCH_W) begin
                        idx = idx - NCH_W;
                    end
                    for (int i = 0; i < NCH; i++) begin
                        if ((idx[SELW-1:0] == SELW'(i)) && in_valid[i]) begin
                            grant    = '0;
                            grant[i] = 1'b1;
                        end
                    end
                end
            end
            default: begin
                for (int i = 0; i < NCH; i++) begin
                    if (sel == SELW'(i)) begin
                        grant[i] = in_valid[i];
                    end
                end
            end
        endcase
    end

    always_comb begin
        win_idx  = '0;
        win_word = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                win_idx  = SELW'(i);
                win_word = ch_word[i];
            end
        end
    end

    assign space    = ~out_valid_q | out_ready;
    assign in_ready = grant & {NCH{space}};
    assign xfer     = |in_ready;

    always_comb begin
        out_valid_d = xfer | (out_valid_q & ~out_ready);
        out_data_d  = xfer ? win_word : out_data_q;
        out_ch_d    = xfer ? win_idx : out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (win_idx == SELW'(NCH-1)) ? '0 : win_idx + SELW'(1);
        end
        err_sel_d   = err_sel_q | (fixed_mode & sel_bad & (|in_valid));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
            err_sel_q   <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
            err_sel_q   <= err_sel_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign err_sel   = err_sel_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Bench for stream_mux_arb: scoreboard of expected words, popped when the consumer accepts.
module tb_stream_mux_arb;

    typedef struct {
        logic [7:0] d;
        logic [1:0] ch;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic [1:0]  sel;
    logic [7:0]  ch_dat [3];
    logic [23:0] in_data;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready, z_in_ready;
    logic [7:0]  out_data, z_out_data;
    logic        out_valid, z_out_valid;
    logic        out_ready;
    logic [1:0]  out_ch, z_out_ch;
    logic        err_sel, z_err_sel;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    assign in_data = {ch_dat[2], ch_dat[1], ch_dat[0]};

    stream_mux_arb #(.NCH(3), .WIDTH(8), .NARROW_W(3), .PAD_ONES(1), .SELW(2)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .err_sel(err_sel)
    );

    stream_mux_arb #(.NCH(3), .WIDTH(8), .NARROW_W(3), .PAD_ONES(0), .SELW(2)) dut_z (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
        .in_valid(in_valid), .in_ready(z_in_ready), .out_data(z_out_data),
        .out_valid(z_out_valid), .out_ready(out_ready), .out_ch(z_out_ch), .err_sel(z_err_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_word(input int ch, input logic [7:0] w, input bit ones);
        if (ch != 2) return w;
        return ones ? {5'b11111, w[2:0]} : {5'b00000, w[2:0]};
    endfunction

    function automatic logic [2:0] onehot(input int ch);
        logic [2:0] v;
        v = 3'b000;
        v[ch] = 1'b1;
        return v;
    endfunction

    // Scoreboard side: every accepted output word must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected: got data=%h ch=%0d, required no word", out_data, out_ch);
            end else begin
                e = sbq.pop_front();
                if (out_data !== e.d || out_ch !== e.ch) begin
                    failures++;
                    $display("FAIL sb_word: got data=%h ch=%0d, required data=%h ch=%0d",
                             out_data, out_ch, e.d, e.ch);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 3'b000;
        out_ready = 1'b1;
        mode      = 2'b00;
        sel       = 2'd0;
        rst_n     = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_data(input int c);
        for (int i = 0; i < 3; i++) ch_dat[i] = 8'((c * 37 + i * 11 + 5) & 8'hFF);
    endtask

    task automatic test_reset();
        do_reset();
        mode = 2'b00; sel = 2'd0; ch_dat[0] = 8'h5A; in_valid = 3'b001; out_ready = 1'b0;
        tick();
        in_valid = 3'b000;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL reset_pre_held: out_valid=%b required 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: out_valid=%b required 0", out_valid);
        end
        checks++;
        if (out_data !== 8'h00 || out_ch !== 2'd0) begin
            failures++; $display("FAIL reset_data: data=%h ch=%0d required 00/0", out_data, out_ch);
        end
        checks++;
        if (err_sel !== 1'b0) begin
            failures++; $display("FAIL reset_err: err_sel=%b required 0", err_sel);
        end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 2'b00; sel = 2'd1; ch_dat[0] = 8'hAA; ch_dat[1] = 8'h0F; ch_dat[2] = 8'h00;
        in_valid = 3'b011;
        #1;
        checks++;
        if (in_ready !== 3'b010) begin
            failures++; $display("FAIL fixed_ready: in_ready=%b required 010", in_ready);
        end
        sbq.push_back('{d: 8'h0F, ch: 2'd1});
        tick();
        mode = 2'b11; sel = 2'd0; ch_dat[0] = 8'h3C;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h0F || out_ch !== 2'd1) begin
            failures++; $display("FAIL fixed_out: v=%b data=%h ch=%0d required 1/0f/1", out_valid, out_data, out_ch);
        end
        checks++;
        if (in_ready !== 3'b001) begin
            failures++; $display("FAIL mode3_ready: in_ready=%b required 001", in_ready);
        end
        sbq.push_back('{d: 8'h3C, ch: 2'd0});
        tick();
        in_valid = 3'b000;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h3C || out_ch !== 2'd0) begin
            failures++; $display("FAIL drain_hold: v=%b data=%h ch=%0d required 0/3c/0", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_narrow();
        logic [7:0] words [2];
        words[0] = 8'hA2;
        words[1] = 8'h5D;
        do_reset();
        mode = 2'b00; sel = 2'd2;
        for (int k = 0; k < 2; k++) begin
            ch_dat[2] = words[k];
            in_valid = 3'b100;
            sbq.push_back('{d: exp_word(2, words[k], 1'b1), ch: 2'd2});
            tick();
            in_valid = 3'b000;
            checks++;
            if (out_data !== exp_word(2, words[k], 1'b1)) begin
                failures++; $display("FAIL pad_ones: data=%h required %h", out_data, exp_word(2, words[k], 1'b1));
            end
            checks++;
            if (z_out_data !== exp_word(2, words[k], 1'b0) || z_out_ch !== 2'd2) begin
                failures++; $display("FAIL pad_zeros: data=%h ch=%0d required %h/2", z_out_data, z_out_ch, exp_word(2, words[k], 1'b0));
            end
            tick();
        end
    endtask

    task automatic run_arb(input logic [1:0] m, input bit rr);
        do_reset();
        mode = m; in_valid = 3'b111; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            int ch;
            ch = rr ? (c % 3) : 0;
            set_data(c);
            #1;
            checks++;
            if (in_ready !== onehot(ch)) begin
                failures++; $display("FAIL arb_ready m=%0d c=%0d: in_ready=%b required %b", m, c, in_ready, onehot(ch));
            end
            sbq.push_back('{d: exp_word(ch, ch_dat[ch], 1'b1), ch: 2'(ch)});
            tick();
        end
        in_valid = 3'b000;
        repeat (2) tick();
    endtask

    task automatic test_round_robin();
        run_arb(2'b10, 1'b1);
    endtask

    task automatic test_priority();
        run_arb(2'b01, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        do_reset();
        mode = 2'b10; in_valid = 3'b111; out_ready = 1'b1;
        set_data(0);
        held = ch_dat[0];
        sbq.push_back('{d: held, ch: 2'd0});
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_data(k + 1);
            if (k == 2) begin
                mode = 2'b01; sel = 2'd2;
            end
            #1;
            checks++;
            if (in_ready !== 3'b000) begin
                failures++; $display("FAIL bp_ready k=%0d: in_ready=%b required 000", k, in_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || out_data !== held || out_ch !== 2'd0) begin
                failures++; $display("FAIL bp_hold k=%0d: v=%b data=%h ch=%0d required 1/%h/0", k, out_valid, out_data, out_ch, held);
            end
            tick();
        end
        mode = 2'b10; out_ready = 1'b1;
        for (int c = 1; c < 6; c++) begin
            int ch;
            ch = c % 3;
            set_data(c + 10);
            #1;
            checks++;
            if (in_ready !== onehot(ch)) begin
                failures++; $display("FAIL bp_release c=%0d: in_ready=%b required %b", c, in_ready, onehot(ch));
            end
            sbq.push_back('{d: exp_word(ch, ch_dat[ch], 1'b1), ch: 2'(ch)});
            tick();
        end
        in_valid = 3'b000;
        repeat (2) tick();
    endtask

    task automatic test_bad_sel();
        do_reset();
        mode = 2'b00; sel = 2'd3; in_valid = 3'b111; set_data(3);
        #1;
        checks++;
        if (in_ready !== 3'b000 || err_sel !== 1'b0) begin
            failures++; $display("FAIL badsel_ready: in_ready=%b err=%b required 000/0", in_ready, err_sel);
        end
        tick();
        checks++;
        if (err_sel !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL badsel_err: err=%b v=%b required 1/0", err_sel, out_valid);
        end
        sel = 2'd0;
        sbq.push_back('{d: ch_dat[0], ch: 2'd0});
        tick();
        in_valid = 3'b000;
        repeat (2) tick();
        checks++;
        if (err_sel !== 1'b1) begin
            failures++; $display("FAIL badsel_sticky: err=%b required 1", err_sel);
        end
        do_reset();
        checks++;
        if (err_sel !== 1'b0) begin
            failures++; $display("FAIL badsel_clear: err=%b required 0", err_sel);
        end
    endtask

    initial begin
        rst_n = 1'b0; mode = 2'b00; sel = 2'd0; in_valid = 3'b000; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) ch_dat[i] = 8'h00;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0 || err_sel !== 1'b0) begin
            failures++; $display("FAIL init_reset: v=%b data=%h ch=%0d err=%b required all 0", out_valid, out_data, out_ch, err_sel);
        end
        test_reset();
        test_fixed();
        test_narrow();
        test_round_robin();
        test_priority();
        test_backpressure();
        test_bad_sel();
        checks++;
        if (sbq.size() != 0) begin
            failures++; $display("FAIL sb_leftover: %0d words never delivered, required 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
